count_wrap_monitor: RTL and testbench

- Sits directly downstream of the 3-bit T-flip-flop counter (counter_t_ff) and consumes its count output plus the same toggle-enable the counter receives.
- Checks every count transition for legality (hold or +1 modulo 2^CNT_W) and counts wrap-arounds (max to 0).
- Flags illegal jumps with a sticky error and captures the offending value.
- Gives the counter stage a self-checking consumer in-system and in sim.

---
 rtl/cnt_mon_pkg.sv | 17 +
 rtl/count_wrap_monitor.sv | 127 ++++++++++++
 tb/tb_count_wrap_monitor.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cnt_mon_pkg.sv
// Shared constants for the T-flip-flop counter stage and its wrap/legality monitor.
package cnt_mon_pkg;

  localparam int CNT_W_DEF  = 3;
  localparam int WRAP_W_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_TRACK = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_TRACK = ST_TRACK,
    S_ERROR = ST_ERROR
  } state_e;

endpackage

// File: rtl/count_wrap_monitor.sv
// Checks each upstream count transition (hold or +1) and counts max->0 wraps.
// Define CNT_MON_TGL_CHECK_EN to also require the count to advance iff the previous toggle-enable was high.
module count_wrap_monitor
  import cnt_mon_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              tgl_i,
  input  logic              clear_i,
  output logic              wrap_o,
  output logic [WRAP_W-1:0] wrap_cnt_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  err_val_o,
  output logic [1:0]        state_o
);

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    prev_q, prev_d;
  logic                tgl_q;
  logic                wrap_q, wrap_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_val_q, err_val_d;

  logic [CNT_W-1:0]    delta_s;
  logic                tgl_err_s;
  logic                illegal_s;
  logic                is_wrap_s;

  assign delta_s   = cnt_i - prev_q;
  assign is_wrap_s = (prev_q == CNT_MAX) && (cnt_i == CNT_ZERO);

`ifdef CNT_MON_TGL_CHECK_EN
  // Strict T-FF semantics: advance exactly when the previous edge had toggle high.
  assign tgl_err_s = ((delta_s == CNT_ONE) && !tgl_q) || ((delta_s == CNT_ZERO) && tgl_q);
`else
  logic tgl_unused_s;
  assign tgl_unused_s = tgl_q;
  assign tgl_err_s    = 1'b0;
`endif

  assign illegal_s = ((delta_s != CNT_ZERO) && (delta_s != CNT_ONE)) || tgl_err_s;

  // Next-state and next-output computation; clear overrides every state.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = err_q;
    err_val_d  = err_val_q;
    if (clear_i) begin
      state_d    = S_IDLE;
      wrap_cnt_d = {WRAP_W{1'b0}};
      err_d      = 1'b0;
      err_val_d  = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          prev_d  = cnt_i;
          state_d = S_TRACK;
        end
        S_TRACK: begin
          if (illegal_s) begin
            state_d   = S_ERROR;
            prev_d    = cnt_i;
            err_d     = 1'b1;
            err_val_d = cnt_i;
          end else if (delta_s == CNT_ONE) begin
            prev_d = cnt_i;
            if (is_wrap_s) begin
              wrap_d     = 1'b1;
              wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
            end else begin
              wrap_d = 1'b0;
            end
          end else begin
            prev_d = prev_q;
          end
        end
        S_ERROR: begin
          prev_d = cnt_i;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      prev_q     <= CNT_ZERO;
      tgl_q      <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= {WRAP_W{1'b0}};
      err_q      <= 1'b0;
      err_val_q  <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      tgl_q      <= tgl_i;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      err_q      <= err_d;
      err_val_q  <= err_val_d;
    end
  end

  assign wrap_o     = wrap_q;
  assign wrap_cnt_o = wrap_cnt_q;
  assign err_o      = err_q;
  assign err_val_o  = err_val_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed, table-driven bench for count_wrap_monitor (CNT_W=3, WRAP_W=4).
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [2:0] cnt_i;
  logic       tgl_i;
  logic       clear_i;
  logic       wrap_o;
  logic [3:0] wrap_cnt_o;
  logic       err_o;
  logic [2:0] err_val_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  count_wrap_monitor #(.CNT_W(3), .WRAP_W(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .cnt_i      (cnt_i),
    .tgl_i      (tgl_i),
    .clear_i    (clear_i),
    .wrap_o     (wrap_o),
    .wrap_cnt_o (wrap_cnt_o),
    .err_o      (err_o),
    .err_val_o  (err_val_o),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cnt;
    logic       tgl;
    logic       clr;
    logic       wrap;
    logic [3:0] wcnt;
    logic       err;
    logic [2:0] errval;
    logic [1:0] state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] c, input logic t, input logic clr,
                              input logic w, input logic [3:0] wc, input logic e,
                              input logic [2:0] ev, input logic [1:0] st);
    vec_t v;
    v.cnt = c; v.tgl = t; v.clr = clr; v.wrap = w; v.wcnt = wc;
    v.err = e; v.errval = ev; v.state = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic w, input logic [3:0] wc, input logic e,
                         input logic [2:0] ev, input logic [1:0] st);
    chk({nm, ".wrap_o"},     {31'd0, wrap_o},     {31'd0, w});
    chk({nm, ".wrap_cnt_o"}, {28'd0, wrap_cnt_o}, {28'd0, wc});
    chk({nm, ".err_o"},      {31'd0, err_o},      {31'd0, e});
    chk({nm, ".err_val_o"},  {29'd0, err_val_o},  {29'd0, ev});
    chk({nm, ".state_o"},    {30'd0, state_o},    {30'd0, st});
  endtask

  // Drive inputs, take one rising edge, and settle just after it.
  task automatic step(input logic [2:0] c, input logic t, input logic clr);
    cnt_i = c; tgl_i = t; clear_i = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] wmodel;
    logic [2:0] v;
    int         wraps;

    // Test 1: two full count cycles plus one (17 edges), wraps on i=8 and i=16.
    for (int i = 0; i < 17; i++) begin
      vecs.push_back(mk(3'(i % 8), 1'b1, 1'b0, (i == 8) || (i == 16),
                        (i >= 16) ? 4'd2 : ((i >= 8) ? 4'd1 : 4'd0),
                        1'b0, 3'd0, 2'b01));
    end
    // Test 2: illegal 2->5 jump, then a 7->0 wrap while in ERROR.
    vecs.push_back(mk(3'd1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 3'd0, 2'b01));
    vecs.push_back(mk(3'd2, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 3'd0, 2'b01));
    vecs.push_back(mk(3'd5, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 3'd5, 2'b10));
    vecs.push_back(mk(3'd6, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 3'd5, 2'b10));
    vecs.push_back(mk(3'd7, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 3'd5, 2'b10));
    vecs.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 3'd5, 2'b10));
    vecs.push_back(mk(3'd3, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 3'd5, 2'b10));
    // Test 3: clear from ERROR, then resync into TRACK.
    vecs.push_back(mk(3'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 2'b00));
    vecs.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 2'b01));
    vecs.push_back(mk(3'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 2'b01));

    reset_i = 1'b0; cnt_i = 3'd0; tgl_i = 1'b0; clear_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 1'b0, 4'd0, 1'b0, 3'd0, 2'b00);
    reset_i = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].cnt, vecs[i].tgl, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].wrap, vecs[i].wcnt, vecs[i].err,
              vecs[i].errval, vecs[i].state);
    end

    // Test 4: 16 wraps roll wrap_cnt_o 15 -> 0 with no error.
    v = 3'd1; wmodel = 4'd0; wraps = 0;
    while (wraps < 16) begin
      v = v + 3'd1;
      step(v, 1'b1, 1'b0);
      if (v == 3'd0) begin
        wraps++;
        wmodel = wmodel + 4'd1;
      end
      chk_all($sformatf("roll_v%0d_w%0d", v, wraps), v == 3'd0, wmodel, 1'b0, 3'd0, 2'b01);
    end
    chk("roll_final_wcnt", {28'd0, wrap_cnt_o}, 32'd0);
    for (int k = 1; k < 8; k++) step(3'(k), 1'b1, 1'b0);
    // Clear coinciding with a 7->0 wrap: no pulse, no increment.
    step(3'd0, 1'b1, 1'b1);
    chk_all("clear_wrap", 1'b0, 4'd0, 1'b0, 3'd0, 2'b00);

    // Test 5: asynchronous reset between edges.
    step(3'd1, 1'b1, 1'b0);
    step(3'd2, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
    chk_all("pre_async", 1'b0, 4'd0, 1'b0, 3'd0, 2'b01);
    #2 reset_i = 1'b0;
    #1 chk_all("async_rst", 1'b0, 4'd0, 1'b0, 3'd0, 2'b00);
    @(posedge clk); #1;
    reset_i = 1'b1;
    #1 chk_all("post_rst_idle", 1'b0, 4'd0, 1'b0, 3'd0, 2'b00);
    step(3'd3, 1'b0, 1'b0);
    chk_all("post_rst_track", 1'b0, 4'd0, 1'b0, 3'd0, 2'b01);

    // Test 6: 3->4 with the previous toggle low, then a hold with toggle high.
    step(3'd4, 1'b0, 1'b0);
`ifdef CNT_MON_TGL_CHECK_EN
    chk_all("tgl_adv_low", 1'b0, 4'd0, 1'b1, 3'd4, 2'b10);
`else
    chk_all("tgl_adv_low", 1'b0, 4'd0, 1'b0, 3'd0, 2'b01);
`endif
    step(3'd4, 1'b1, 1'b1);
    chk_all("tgl_clear", 1'b0, 4'd0, 1'b0, 3'd0, 2'b00);
    step(3'd4, 1'b1, 1'b0);
    chk_all("tgl_resync", 1'b0, 4'd0, 1'b0, 3'd0, 2'b01);
    step(3'd4, 1'b1, 1'b0);
`ifdef CNT_MON_TGL_CHECK_EN
    chk_all("tgl_hold_high", 1'b0, 4'd0, 1'b1, 3'd4, 2'b10);
`else
    chk_all("tgl_hold_high", 1'b0, 4'd0, 1'b0, 3'd0, 2'b01);
`endif

    // Clear coinciding with an illegal jump: clear wins.
    step(3'd7, 1'b1, 1'b1);
    step(3'd7, 1'b1, 1'b0);
    chk_all("track7", 1'b0, 4'd0, 1'b0, 3'd0, 2'b01);
    step(3'd2, 1'b1, 1'b1);
    chk_all("clear_illegal", 1'b0, 4'd0, 1'b0, 3'd0, 2'b00);
    step(3'd2, 1'b1, 1'b0);
    chk_all("clear_illegal_resync", 1'b0, 4'd0, 1'b0, 3'd0, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
